xgmii_loopback_channel: RTL and testbench
=========================================

# xgmii_loopback_channel

Parametrised XGMII loopback channel that replaces the bare xgmii_txd/txc to xgmii_rxd/rxc wire used in MAC loopback benches. It sits between the MAC transmit and receive XGMII ports and adds:
- programmable pipeline latency;
- frame-aware mode switching (pass, forced idle, forced local fault);
- one-shot data corruption;
- optional link statistics.

It lets the team exercise MAC receive error, fault and latency paths without an external PHY model.

## Interface
- LANES, 8: XGMII byte lanes per word; multiple of 4, range 4..16.
- DELAY, 2: clk-to-output latency in cycles; range 1..16.
- CNT_W, 32: statistics counter width.
- clk_xgmii_tx  in  1  single clock; all logic on rising edge.
- rst_xgmii_tx  in  1  reset, synchronous, active-high.
- xgmii_txd  in  8*LANES  transmit data from MAC; lane n = bits [8n+7:8n].
- xgmii_txc  in  LANES  transmit control; bit n flags lane n as control.
- xgmii_rxd  out  8*LANES  looped data to MAC receive.
- xgmii_rxc  out  LANES  looped control to MAC receive.
- cfg_mode  in  2  00 pass, 01 force idle, 10 force local fault, 11 reserved (treated as 00).
- corrupt_req  in  1  one-cycle pulse; arms a single corruption.
- corrupt_mask  in  8*LANES  XOR mask; sampled when corrupt_req is high.
- corrupt_done  out  1  one-cycle pulse when the armed corruption is applied.
- stat_clr  in  1  synchronous clear of all counters.
- frame_cnt  out  CNT_W  start characters seen on xgmii_rxd.
- err_cnt  out  CNT_W  output words containing an error control character (0xFE).

## Operation
- **Input decode.** Each lane is evaluated per word at stage 0.
  - SOF: lane k with k%4==0, txc[k]=1, data 0xFB.
  - EOF: any lane with txc=1 and data 0xFD.
- **Frame FSM.** Two states, IDLE and IN_FRAME.
  - IDLE -> IN_FRAME on SOF without a later EOF in the same word.
  - IN_FRAME -> IDLE on EOF.
  - SOF and EOF in one word (SOF lane < EOF lane) stays IDLE.
  - SOF while IN_FRAME stays IN_FRAME; no error is flagged.
- **Mode latching.** active_mode loads cfg_mode only on cycles where the FSM is IDLE and the current word has no SOF. A mode change therefore never truncates or splices a frame.
- **Stage-0 output word by active_mode.**
  - Pass: input unchanged.
  - Force idle: every lane 0x07 with ctrl=1.
  - Force local fault: each 4-lane column = {0x9C ctrl, 0x00, 0x00, 0x01 data}, rxc column = 4'b0001.
  - While forced, the FSM still tracks input frames, so a return to pass waits for an input frame boundary.
- **Corruption.**
  - corrupt_req loads corrupt_mask and sets armed.
  - While armed, the first pass-mode word that is IN_FRAME (entered before this cycle) with txc all zero is XORed with the mask. armed then clears and corrupt_done pulses in that same stage-0 cycle.
  - corrupt_req while already armed reloads the mask and stays armed.
  - Control bits are never corrupted.
- **Delay line.** The stage-0 register feeds DELAY-1 further registers. xgmii_rxd/rxc is the last stage.
- **Statistics** are decoded on the xgmii_rxd/rxc output.
  - frame_cnt increments once per word containing an output SOF.
  - err_cnt increments once per word with any lane at txc=1, data 0xFE.
  - Both saturate at all-ones.
  - stat_clr has priority over a same-cycle increment; the counter reads 0 next cycle.

## Timing
- **Latency.** Input word at edge t appears on xgmii_rxd/rxc after edge t+DELAY-1, i.e. DELAY cycles registered; DELAY=1 means only the stage-0 register.
- **corrupt_done** is asserted after the stage-0 edge of the corrupted word, DELAY-1 cycles before that word reaches the output.
- **Counter update** is one cycle after the counted word is on the output.
- **Reset values.**
  - Every pipeline stage holds idle (data 0x07 per lane, rxc all ones).
  - FSM in IDLE, active_mode = pass, armed = 0, corrupt_done = 0, both counters 0.
- **Reset mid-frame.** The frame is dropped. Output is idle on the cycle after the reset edge; the output never carries a partial EOF.
- **cfg_mode change mid-frame** takes effect on the first IDLE cycle after the input EOF word.

## Configuration
- **XGMII_LB_STATS_EN defined:** output decode, frame_cnt and err_cnt are implemented as above.
- **Not defined:** counter logic is removed, frame_cnt and err_cnt are tied to 0, and stat_clr is ignored. Datapath behaviour and latency are identical.

## Test plan
- **Latency, DELAY=3, LANES=8, pass.** Drive 0xFB start word at cycle 10, 8 data words, 0xFD terminate -> identical words on xgmii_rxd at cycles 13..22; frame_cnt = 1 at cycle 14.
- **Mode change mid-frame.** cfg_mode=01 asserted on data word 4 of a 10-word frame -> full frame passes unchanged; first word after EOF is all-0x07/rxc 0xFF.
- **Local fault.** cfg_mode=10 in idle -> output 0x0100009C_0100009C, rxc 0x11 every cycle. Return to 00 -> next input frame passes.
- **Corruption.** Pulse corrupt_req with mask 0x00000000_000000FF before a frame -> only the first all-data word has its lane 0 byte inverted; corrupt_done pulses once; a second frame is clean.
- **Counters.** Inject 3 words containing 0xFE ctrl -> err_cnt = 3. With CNT_W=4, send 20 frames -> frame_cnt = 15. stat_clr coincident with an SOF output -> 0.
- **Reset mid-frame** at data word 3 -> output idle from the next cycle, all counters 0, next frame forwarded intact.

Source files
------------

// File: rtl/xgmii_loopback_channel.sv
// XGMII loopback channel: MAC TX -> MAC RX with programmable latency,
// frame-aware pass / forced-idle / forced-local-fault modes, one-shot
// data corruption and optional link statistics.
// Optional feature macro: XGMII_LB_STATS_EN (frame_cnt / err_cnt counters).
module xgmii_loopback_channel #(
    parameter int unsigned LANES = 8,
    parameter int unsigned DELAY = 2,
    parameter int unsigned CNT_W = 32
) (
    input  logic               clk_xgmii_tx,
    input  logic               rst_xgmii_tx,
    input  logic [8*LANES-1:0] xgmii_txd,
    input  logic [LANES-1:0]   xgmii_txc,
    output logic [8*LANES-1:0] xgmii_rxd,
    output logic [LANES-1:0]   xgmii_rxc,
    input  logic [1:0]         cfg_mode,
    input  logic               corrupt_req,
    input  logic [8*LANES-1:0] corrupt_mask,
    output logic               corrupt_done,
    input  logic               stat_clr,
    output logic [CNT_W-1:0]   frame_cnt,
    output logic [CNT_W-1:0]   err_cnt
);

    localparam int unsigned DW   = 8 * LANES;
    localparam int unsigned COLS = LANES / 4;

    localparam logic [DW-1:0]    IDLE_D  = {LANES{8'h07}};
    localparam logic [DW-1:0]    FAULT_D = {COLS{32'h0100_009C}};
    localparam logic [LANES-1:0] FAULT_C = {COLS{4'b0001}};

    typedef enum logic [1:0] {
        MODE_PASS  = 2'b00,
        MODE_IDLE  = 2'b01,
        MODE_FAULT = 2'b10,
        MODE_RSVD  = 2'b11
    } mode_t;

    typedef enum logic {
        ST_IDLE,
        ST_IN_FRAME
    } state_t;

    state_t           state;
    state_t           state_nxt;
    mode_t            active_mode;
    logic             armed;
    logic [DW-1:0]    mask_q;
    logic             sof_any;
    logic             eof_any;
    logic             frame_open;
    logic             mode_load;
    logic             corrupt_hit;
    logic [DW-1:0]    s0_d;
    logic [LANES-1:0] s0_c;
    logic [DW-1:0]    pipe_d [DELAY];
    logic [LANES-1:0] pipe_c [DELAY];

    // Input word decode; frame_open means the last start in the word is not followed by a terminate
    always_comb begin
        sof_any    = 1'b0;
        eof_any    = 1'b0;
        frame_open = 1'b0;
        for (int unsigned k = 0; k < LANES; k++) begin
            if (xgmii_txc[k] && xgmii_txd[8*k +: 8] == 8'hFD) begin
                eof_any    = 1'b1;
                frame_open = 1'b0;
            end
            if ((k % 4) == 0 && xgmii_txc[k] && xgmii_txd[8*k +: 8] == 8'hFB) begin
                sof_any    = 1'b1;
                frame_open = 1'b1;
            end
        end
    end

    // Frame FSM state register
    always_ff @(posedge clk_xgmii_tx) begin
        if (rst_xgmii_tx) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Frame FSM next state and mode-latch enable
    always_comb begin
        state_nxt = state;
        mode_load = 1'b0;
        case (state)
            ST_IDLE: begin
                mode_load = !sof_any;
                if (frame_open) begin
                    state_nxt = ST_IN_FRAME;
                end
            end
            ST_IN_FRAME: begin
                if (eof_any) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Stage-0 word selection by active mode, with one-shot corruption of all-data frame words
    always_comb begin
        corrupt_hit = armed && (active_mode == MODE_PASS) && (state == ST_IN_FRAME)
                      && (xgmii_txc == '0);
        s0_d = xgmii_txd;
        s0_c = xgmii_txc;
        case (active_mode)
            MODE_IDLE: begin
                s0_d = IDLE_D;
                s0_c = '1;
            end
            MODE_FAULT: begin
                s0_d = FAULT_D;
                s0_c = FAULT_C;
            end
            default: begin
                if (corrupt_hit) begin
                    s0_d = xgmii_txd ^ mask_q;
                end
            end
        endcase
    end

    // Mode latch and corruption arming; reserved mode is stored as pass
    always_ff @(posedge clk_xgmii_tx) begin
        if (rst_xgmii_tx) begin
            active_mode  <= MODE_PASS;
            armed        <= 1'b0;
            mask_q       <= '0;
            corrupt_done <= 1'b0;
        end else begin
            if (mode_load) begin
                active_mode <= (cfg_mode == 2'b11) ? MODE_PASS : mode_t'(cfg_mode);
            end
            corrupt_done <= corrupt_hit;
            if (corrupt_req) begin
                mask_q <= corrupt_mask;
                armed  <= 1'b1;
            end else if (corrupt_hit) begin
                armed <= 1'b0;
            end
        end
    end

    // Stage-0 register followed by DELAY-1 delay stages, all idle after reset
    always_ff @(posedge clk_xgmii_tx) begin
        if (rst_xgmii_tx) begin
            for (int unsigned i = 0; i < DELAY; i++) begin
                pipe_d[i] <= IDLE_D;
                pipe_c[i] <= '1;
            end
        end else begin
            pipe_d[0] <= s0_d;
            pipe_c[0] <= s0_c;
            for (int unsigned i = 1; i < DELAY; i++) begin
                pipe_d[i] <= pipe_d[i-1];
                pipe_c[i] <= pipe_c[i-1];
            end
        end
    end

    assign xgmii_rxd = pipe_d[DELAY-1];
    assign xgmii_rxc = pipe_c[DELAY-1];

`ifdef XGMII_LB_STATS_EN
    logic out_sof;
    logic out_err;

    // Output word decode for statistics
    always_comb begin
        out_sof = 1'b0;
        out_err = 1'b0;
        for (int unsigned k = 0; k < LANES; k++) begin
            if (xgmii_rxc[k] && xgmii_rxd[8*k +: 8] == 8'hFE) begin
                out_err = 1'b1;
            end
            if ((k % 4) == 0 && xgmii_rxc[k] && xgmii_rxd[8*k +: 8] == 8'hFB) begin
                out_sof = 1'b1;
            end
        end
    end

    // Saturating counters; clear wins over a same-cycle increment
    always_ff @(posedge clk_xgmii_tx) begin
        if (rst_xgmii_tx || stat_clr) begin
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            if (out_sof && frame_cnt != '1) begin
                frame_cnt <= frame_cnt + CNT_W'(1);
            end
            if (out_err && err_cnt != '1) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
        end
    end
`else
    logic unused_stat_clr;

    assign unused_stat_clr = stat_clr;
    assign frame_cnt       = '0;
    assign err_cnt         = '0;
`endif

endmodule

// File: tb/tb_xgmii_loopback_channel.sv
// Self-checking bench for xgmii_loopback_channel (LANES=8, DELAY=3, CNT_W=4):
// directed scenarios plus randomized traffic against a word-level reference model.
module tb_xgmii_loopback_channel;

    localparam int unsigned LANES = 8;
    localparam int unsigned DELAY = 3;
    localparam int unsigned CNT_W = 4;
    localparam int          CNT_MAX = 15;
`ifdef XGMII_LB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    localparam logic [63:0] IDLE_D  = 64'h0707_0707_0707_0707;
    localparam logic [63:0] FAULT_D = 64'h0100_009C_0100_009C;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] txd;
    logic [7:0]  txc;
    logic [63:0] rxd;
    logic [7:0]  rxc;
    logic [1:0]  cfg_mode;
    logic        corrupt_req;
    logic [63:0] corrupt_mask;
    logic        corrupt_done;
    logic        stat_clr;
    logic [CNT_W-1:0] frame_cnt;
    logic [CNT_W-1:0] err_cnt;

    always #5 clk = ~clk;

    xgmii_loopback_channel #(.LANES(LANES), .DELAY(DELAY), .CNT_W(CNT_W)) dut (
        .clk_xgmii_tx (clk),
        .rst_xgmii_tx (rst),
        .xgmii_txd    (txd),
        .xgmii_txc    (txc),
        .xgmii_rxd    (rxd),
        .xgmii_rxc    (rxc),
        .cfg_mode     (cfg_mode),
        .corrupt_req  (corrupt_req),
        .corrupt_mask (corrupt_mask),
        .corrupt_done (corrupt_done),
        .stat_clr     (stat_clr),
        .frame_cnt    (frame_cnt),
        .err_cnt      (err_cnt)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: queue of words in flight (front = word on the output)
    logic [63:0] q_d[$];
    logic [7:0]  q_c[$];
    bit          m_in_frame;
    int          m_mode;
    bit          m_armed;
    logic [63:0] m_mask;
    bit          m_done;
    int          m_frames;
    int          m_errs;
    int          done_pulses;
    bit          rnd;

    function automatic logic [7:0] lane(input logic [63:0] d, input int k);
        return d[8*k +: 8];
    endfunction

    task automatic model_reset();
        q_d.delete();
        q_c.delete();
        for (int i = 0; i < DELAY; i++) begin
            q_d.push_back(IDLE_D);
            q_c.push_back(8'hFF);
        end
        m_in_frame = 1'b0;
        m_mode     = 0;
        m_armed    = 1'b0;
        m_mask     = '0;
        m_done     = 1'b0;
        m_frames   = 0;
        m_errs     = 0;
    endtask

    task automatic rand_side();
        if ($urandom_range(39) == 0) cfg_mode = 2'($urandom_range(3));
        corrupt_req  = ($urandom_range(29) == 0);
        corrupt_mask = {$urandom, $urandom};
        stat_clr     = ($urandom_range(99) == 0);
        rst          = ($urandom_range(699) == 0);
    endtask

    // One clock: advance the model with the current inputs, clock the DUT, compare
    task automatic step();
        logic [63:0] od;
        logic [7:0]  oc;
        bit          hit;
        bit          o_sof;
        bit          o_err;
        int          last_sof;
        int          last_eof;
        if (rnd) rand_side();
        if (rst) begin
            model_reset();
        end else begin
            o_sof = 1'b0;
            o_err = 1'b0;
            for (int k = 0; k < 8; k++) begin
                if (q_c[0][k] && lane(q_d[0], k) == 8'hFE) o_err = 1'b1;
                if (k % 4 == 0 && q_c[0][k] && lane(q_d[0], k) == 8'hFB) o_sof = 1'b1;
            end
            if (STATS) begin
                if (stat_clr) begin
                    m_frames = 0;
                    m_errs   = 0;
                end else begin
                    if (o_sof && m_frames < CNT_MAX) m_frames++;
                    if (o_err && m_errs < CNT_MAX) m_errs++;
                end
            end
            last_sof = -1;
            last_eof = -1;
            for (int k = 0; k < 8; k++) begin
                if (txc[k] && lane(txd, k) == 8'hFD) last_eof = k;
                if (k % 4 == 0 && txc[k] && lane(txd, k) == 8'hFB) last_sof = k;
            end
            hit = m_armed && m_mode == 0 && m_in_frame && txc == 8'h00;
            if (m_mode == 1) begin
                od = IDLE_D;
                oc = 8'hFF;
            end else if (m_mode == 2) begin
                od = FAULT_D;
                oc = 8'h11;
            end else begin
                od = hit ? (txd ^ m_mask) : txd;
                oc = txc;
            end
            if (!m_in_frame && last_sof < 0) m_mode = (cfg_mode == 2'd3) ? 0 : int'(cfg_mode);
            if (m_in_frame) begin
                if (last_eof >= 0) m_in_frame = 1'b0;
            end else if (last_sof > last_eof) begin
                m_in_frame = 1'b1;
            end
            if (corrupt_req) begin
                m_mask  = corrupt_mask;
                m_armed = 1'b1;
            end else if (hit) begin
                m_armed = 1'b0;
            end
            m_done = hit;
            void'(q_d.pop_front());
            void'(q_c.pop_front());
            q_d.push_back(od);
            q_c.push_back(oc);
        end
        @(posedge clk);
        #1;
        check("rxd", rxd, q_d[0]);
        check("rxc", 64'(rxc), 64'(q_c[0]));
        check("corrupt_done", 64'(corrupt_done), 64'(m_done));
        check("frame_cnt", 64'(frame_cnt), 64'(m_frames));
        check("err_cnt", 64'(err_cnt), 64'(m_errs));
        if (corrupt_done) done_pulses++;
    endtask

    task automatic w_idle();
        txd = IDLE_D;
        txc = 8'hFF;
        step();
    endtask

    task automatic w_sof(input bit at4);
        if (at4) begin
            txd = 64'h5555_55FB_0707_0707;
            txc = 8'h1F;
        end else begin
            txd = 64'hD555_5555_5555_55FB;
            txc = 8'h01;
        end
        step();
    endtask

    task automatic w_data();
        txd = {$urandom, $urandom};
        txc = 8'h00;
        step();
    endtask

    task automatic w_err();
        int p;
        p = $urandom_range(7);
        txd = {$urandom, $urandom};
        txd[8*p +: 8] = 8'hFE;
        txc = 8'(1 << p);
        step();
    endtask

    task automatic w_eof(input int p);
        for (int k = 0; k < 8; k++) begin
            if (k < p) begin
                txd[8*k +: 8] = 8'($urandom);
                txc[k] = 1'b0;
            end else begin
                txd[8*k +: 8] = (k == p) ? 8'hFD : 8'h07;
                txc[k] = 1'b1;
            end
        end
        step();
    endtask

    task automatic send_frame(input int n_data, input bit at4, input int eof_lane);
        w_sof(at4);
        for (int i = 0; i < n_data; i++) w_data();
        w_eof(eof_lane);
    endtask

    initial begin
        rnd          = 1'b0;
        rst          = 1'b1;
        txd          = IDLE_D;
        txc          = 8'hFF;
        cfg_mode     = 2'b00;
        corrupt_req  = 1'b0;
        corrupt_mask = '0;
        stat_clr     = 1'b0;
        done_pulses  = 0;
        model_reset();

        // Reset state
        w_idle();
        w_idle();
        check("reset_rxd", rxd, IDLE_D);
        check("reset_rxc", 64'(rxc), 64'hFF);
        check("reset_cnt", 64'(frame_cnt), 64'd0);
        rst = 1'b0;

        // Latency and pass-through
        for (int i = 0; i < 7; i++) w_idle();
        send_frame(8, 1'b0, 3);
        for (int i = 0; i < DELAY + 1; i++) w_idle();
        check("latency_frame_cnt", 64'(frame_cnt), STATS ? 64'd1 : 64'd0);

        // Mode change to force idle in the middle of a frame
        w_sof(1'b0);
        for (int i = 1; i <= 10; i++) begin
            if (i == 4) cfg_mode = 2'b01;
            w_data();
        end
        w_eof(0);
        for (int i = 0; i < DELAY + 2; i++) w_idle();
        send_frame(3, 1'b0, 6);
        w_idle();
        check("forced_idle_rxd", rxd, IDLE_D);

        // Local fault, then back to pass
        cfg_mode = 2'b10;
        for (int i = 0; i < DELAY + 2; i++) w_idle();
        check("fault_rxd", rxd, FAULT_D);
        check("fault_rxc", 64'(rxc), 64'h11);
        cfg_mode = 2'b00;
        w_idle();
        w_idle();
        send_frame(4, 1'b1, 7);
        for (int i = 0; i < DELAY; i++) w_idle();

        // Single corruption of lane 0, second frame clean
        done_pulses  = 0;
        corrupt_req  = 1'b1;
        corrupt_mask = 64'h0000_0000_0000_00FF;
        w_idle();
        corrupt_req  = 1'b0;
        send_frame(4, 1'b0, 2);
        w_idle();
        send_frame(4, 1'b0, 5);
        for (int i = 0; i < DELAY; i++) w_idle();
        check("corrupt_pulses", 64'(done_pulses), 64'd1);

        // Error counter, start and terminate in one word
        stat_clr = 1'b1;
        w_idle();
        stat_clr = 1'b0;
        w_sof(1'b0);
        w_err();
        w_data();
        w_err();
        w_err();
        w_eof(4);
        txd = 64'h0707_FD11_2233_44FB;
        txc = 8'hE1;
        step();
        w_data();
        for (int i = 0; i < DELAY + 1; i++) w_idle();
        check("err_cnt_three", 64'(err_cnt), STATS ? 64'd3 : 64'd0);

        // Frame counter saturation
        for (int f = 0; f < 20; f++) begin
            send_frame(1, f[0], 1);
            w_idle();
        end
        for (int i = 0; i < DELAY; i++) w_idle();
        check("frame_cnt_sat", 64'(frame_cnt), STATS ? 64'd15 : 64'd0);

        // Clear coincident with a start character on the output
        w_sof(1'b0);
        for (int i = 0; i < DELAY - 1; i++) w_data();
        stat_clr = 1'b1;
        w_data();
        stat_clr = 1'b0;
        check("clr_vs_sof", 64'(frame_cnt), 64'd0);
        w_eof(0);
        for (int i = 0; i < DELAY; i++) w_idle();

        // Reset in the middle of a frame
        w_sof(1'b0);
        w_data();
        w_data();
        rst = 1'b1;
        w_data();
        rst = 1'b0;
        check("rst_mid_rxd", rxd, IDLE_D);
        check("rst_mid_cnt", 64'(err_cnt), 64'd0);
        w_data();
        w_eof(3);
        w_idle();
        send_frame(5, 1'b0, 0);
        for (int i = 0; i < DELAY; i++) w_idle();

        // Randomized traffic
        rnd = 1'b1;
        for (int f = 0; f < 150; f++) begin
            int gap;
            gap = $urandom_range(3);
            for (int i = 0; i < gap; i++) w_idle();
            if ($urandom_range(15) == 0) begin
                txd = 64'h0707_FD11_2233_44FB;
                txc = 8'hE1;
                step();
            end else begin
                w_sof($urandom_range(3) == 0);
                for (int i = 0; i < int'($urandom_range(12)); i++) begin
                    if ($urandom_range(9) == 0) w_err();
                    else w_data();
                end
                w_eof(int'($urandom_range(7)));
            end
        end
        rnd         = 1'b0;
        rst         = 1'b0;
        corrupt_req = 1'b0;
        stat_clr    = 1'b0;
        for (int i = 0; i < DELAY + 2; i++) w_idle();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
